// File: rtl/uart_tx.sv
// UART transmitter: start bit, PAYLOAD_BITS data bits LSB-first, optional even parity, stop bits.
// Define UART_TX_PARITY_EN to insert one even-parity bit after the last data bit.
module uart_tx #(
    parameter int unsigned BIT_RATE     = 9600,
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned PAYLOAD_BITS = 8,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    uart_tx_en,
    input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
    output logic                    uart_tx_busy,
    output logic                    uart_txd
);

    // Same bit-period arithmetic as uart_rx so both ends agree on bit length.
    localparam int unsigned BIT_P          = 1_000_000_000 / BIT_RATE;
    localparam int unsigned CLK_P          = 1_000_000_000 / CLK_HZ;
    localparam int unsigned CYCLES_PER_BIT = BIT_P / CLK_P;
    localparam int unsigned CNT_W          = 1 + $clog2(CYCLES_PER_BIT);
    localparam int unsigned BIT_W          = $clog2(PAYLOAD_BITS) + 1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cycle_cnt_q, cycle_cnt_d;
    logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
    logic                    txd_q, txd_d;
    logic                    busy_q, busy_d;
    logic                    bit_done;
`ifdef UART_TX_PARITY_EN
    logic                    parity_q, parity_d;
`endif

    assign bit_done     = (cycle_cnt_q == CNT_W'(CYCLES_PER_BIT - 1));
    assign uart_txd     = txd_q;
    assign uart_tx_busy = busy_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            cycle_cnt_q <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            txd_q       <= 1'b1;
            busy_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cycle_cnt_q <= cycle_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            txd_q       <= txd_d;
            busy_q      <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cycle_cnt_d = cycle_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d    = parity_q;
`endif
        if (state_q != StIdle) begin
            cycle_cnt_d = bit_done ? '0 : cycle_cnt_q + CNT_W'(1);
        end
        unique case (state_q)
            StIdle: begin
                cycle_cnt_d = '0;
                if (uart_tx_en) begin
                    state_d = StStart;
                    shift_d = uart_tx_data;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^uart_tx_data;
`endif
                end
            end
            StStart: begin
                if (bit_done) begin
                    state_d   = StData;
                    bit_cnt_d = '0;
                end
            end
            StData: begin
                if (bit_done) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == BIT_W'(PAYLOAD_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                        bit_cnt_d = '0;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (bit_done) begin
                    state_d   = StStop;
                    bit_cnt_d = '0;
                end
            end
`endif
            // Bit counter is reused to count stop bits.
            StStop: begin
                if (bit_done) begin
                    if (bit_cnt_q == BIT_W'(STOP_BITS - 1)) begin
                        state_d   = StIdle;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_comb begin
        txd_d  = 1'b1;
        busy_d = (state_d != StIdle);
        case (state_d)
            StStart:  txd_d = 1'b0;
            StData:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            StParity: txd_d = parity_q | (parity_d & (state_q == StIdle));
`endif
            default:  txd_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table vectors, random frames, and hand-written corner sequences.
module tb_uart_tx;

    localparam int CPB     = 10;
    localparam int NBITS   = 8;
    localparam int NSTOP   = 1;
`ifdef UART_TX_PARITY_EN
    localparam int NPAR    = 1;
`else
    localparam int NPAR    = 0;
`endif
    localparam int FRAME_BITS = 1 + NBITS + NPAR + NSTOP;
    localparam int EXP_BUSY   = (NPAR != 0) ? 110 : 100;

    logic       clk;
    logic       resetn;
    logic       uart_tx_en;
    logic [7:0] uart_tx_data;
    logic       uart_tx_busy;
    logic       uart_txd;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic cap_wave[$];
    logic model_bits[$];
    int   cap_len;
    int   cap_start;
    logic cap_ok;
    logic cap_end_txd;

    typedef struct {
        logic [7:0] data;
        int         exp_busy;
        logic       exp_parity;
    } vec_t;

    vec_t vecs[7];

    uart_tx #(
        .BIT_RATE    (5_000_000),
        .CLK_HZ      (50_000_000),
        .PAYLOAD_BITS(NBITS),
        .STOP_BITS   (NSTOP)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .uart_tx_en  (uart_tx_en),
        .uart_tx_data(uart_tx_data),
        .uart_tx_busy(uart_tx_busy),
        .uart_txd    (uart_txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference frame as a list of line levels, one entry per bit period.
    task automatic build_model(input logic [7:0] d);
        model_bits.delete();
        model_bits.push_back(1'b0);
        for (int i = 0; i < NBITS; i++) model_bits.push_back(d[i]);
        if (NPAR != 0) model_bits.push_back(^d);
        for (int i = 0; i < NSTOP; i++) model_bits.push_back(1'b1);
    endtask

    task automatic start_frame(input logic [7:0] d);
        @(negedge clk);
        uart_tx_en   = 1'b1;
        uart_tx_data = d;
    endtask

    task automatic capture(input bit hold_en, input logic [7:0] next_data,
                           input int inject_at, input logic [7:0] inject_data);
        int waitc;
        waitc = 0;
        cap_wave.delete();
        cap_len = 0;
        cap_ok  = 1'b1;
        @(negedge clk);
        while (!uart_tx_busy && waitc < 50) begin
            waitc++;
            @(negedge clk);
        end
        if (!uart_tx_busy) begin
            cap_ok = 1'b0;
            uart_tx_en = 1'b0;
            return;
        end
        cap_start = cyc;
        while (uart_tx_busy && cap_len < 5000) begin
            cap_wave.push_back(uart_txd);
            if (cap_len == 0) begin
                uart_tx_data = next_data;
                if (!hold_en) uart_tx_en = 1'b0;
            end
            if (inject_at >= 0 && cap_len == inject_at) begin
                uart_tx_en   = 1'b1;
                uart_tx_data = inject_data;
            end
            if (inject_at >= 0 && cap_len == inject_at + 1) uart_tx_en = 1'b0;
            cap_len++;
            @(negedge clk);
        end
        cap_end_txd = uart_txd;
    endtask

    task automatic compare_frame(input string name, input logic [7:0] d);
        int bad;
        int exp_len;
        check({name, " start"}, 32'(cap_ok), 32'd1);
        if (!cap_ok) return;
        build_model(d);
        exp_len = model_bits.size() * CPB;
        check({name, " busy length"}, cap_len, exp_len);
        bad = -1;
        for (int k = 0; k < cap_len && k < exp_len; k++) begin
            if (bad < 0 && cap_wave[k] !== model_bits[k / CPB]) bad = k;
        end
        check({name, " waveform first bad cycle"}, bad, -1);
        check({name, " idle after frame"}, 32'(cap_end_txd), 32'd1);
    endtask

    task automatic quiet_check(input string name, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (uart_tx_busy !== 1'b0 || uart_txd !== 1'b1) bad++;
        end
        check({name, " bad idle cycles"}, bad, 0);
    endtask

    initial begin
        int s1;
        vecs[0] = '{8'hA5, EXP_BUSY, 1'b0};
        vecs[1] = '{8'h01, EXP_BUSY, 1'b1};
        vecs[2] = '{8'h00, EXP_BUSY, 1'b0};
        vecs[3] = '{8'hFF, EXP_BUSY, 1'b0};
        vecs[4] = '{8'h5A, EXP_BUSY, 1'b0};
        vecs[5] = '{8'h3C, EXP_BUSY, 1'b0};
        vecs[6] = '{8'h80, EXP_BUSY, 1'b1};

        resetn       = 1'b0;
        uart_tx_en   = 1'b0;
        uart_tx_data = 8'h00;
        repeat (5) @(negedge clk);
        check("reset txd", 32'(uart_txd), 32'd1);
        check("reset busy", 32'(uart_tx_busy), 32'd0);
        resetn = 1'b1;
        quiet_check("post-reset", 20);

        foreach (vecs[i]) begin
            start_frame(vecs[i].data);
            capture(1'b0, 8'($urandom), -1, 8'h00);
            compare_frame($sformatf("vec%0d", i), vecs[i].data);
            check($sformatf("vec%0d table busy", i), cap_len, vecs[i].exp_busy);
`ifdef UART_TX_PARITY_EN
            if (cap_len > (1 + NBITS) * CPB + CPB / 2)
                check($sformatf("vec%0d parity bit", i),
                      32'(cap_wave[(1 + NBITS) * CPB + CPB / 2]), 32'(vecs[i].exp_parity));
`endif
            repeat (3) @(negedge clk);
        end

        // Request during a frame must be dropped.
        start_frame(8'hA5);
        capture(1'b0, 8'($urandom), 30, 8'h3C);
        compare_frame("ignored req", 8'hA5);
        quiet_check("no second frame", 300);

        // Back-to-back with en held high.
        start_frame(8'h00);
        capture(1'b1, 8'hFF, -1, 8'h00);
        s1 = cap_start;
        compare_frame("b2b first", 8'h00);
        capture(1'b0, 8'($urandom), -1, 8'h00);
        check("b2b spacing", cap_start - s1, FRAME_BITS * CPB + 1);
        compare_frame("b2b second", 8'hFF);
        repeat (3) @(negedge clk);

        // Reset during the 4th data bit.
        start_frame(8'hC3);
        @(negedge clk);
        uart_tx_en = 1'b0;
        repeat (44) @(negedge clk);
        check("pre-reset busy", 32'(uart_tx_busy), 32'd1);
        resetn = 1'b0;
        #1;
        check("mid-frame reset txd", 32'(uart_txd), 32'd1);
        check("mid-frame reset busy", 32'(uart_tx_busy), 32'd0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        quiet_check("after mid reset", 5);
        start_frame(8'h5A);
        capture(1'b0, 8'($urandom), -1, 8'h00);
        compare_frame("post-reset 5A", 8'h5A);

        for (int r = 0; r < 16; r++) begin
            logic [7:0] d;
            d = 8'($urandom);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            start_frame(d);
            capture(1'b0, 8'($urandom), -1, 8'h00);
            compare_frame($sformatf("rand%0d", r), d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
